// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: CPU handshake states, pipeline tags and
// the starvation counter width.
package vram_arb_pkg;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {C_IDLE, C_ISSUED, C_HOLD} cpu_state_t;
    typedef enum logic [1:0] {T_NONE, T_VID, T_CPU}     tag_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Z80-side request/acknowledge bus into the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int AW = 10
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/vram_arb_starve.sv
// Counts cycles a pending idle CPU request loses to video and raises a force
// flag once it has lost MAX_CPU_WAIT times in a row.
module vram_arb_starve
    import vram_arb_pkg::*;
#(
    parameter int MAX_CPU_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_idle,
    input  logic vid_won,
    input  logic cpu_issued,
    output logic force_cpu
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CPU_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !cpu_req || cpu_issued)
            cnt <= '0;
        else if (cpu_idle && vid_won && cnt != LIMIT)
            cnt <= cnt + CNT_W'(1);
    end

    // Gated by the live request so a stale count cannot issue a dropped access.
    assign force_cpu = cpu_idle && cpu_req && (cnt == LIMIT);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by video fetch (priority) and the Z80; pipelined
// issue -> RAM -> return with a one-deep video latch and CPU starvation bound.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW           = 10,
    parameter int MAX_CPU_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    vram_arbiter_if.slave cpu,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);
    cpu_state_t    state, state_nx;
    tag_t          tag_mem, tag_ret;
    logic          we_ret;
    logic          lat_full;
    logic [AW-1:0] lat_addr;
    logic [AW-1:0] vid_issue_addr;
    logic          issue_cpu, issue_vid, force_cpu, cpu_idle;
    logic [7:0]    vid_hold, cpu_hold;
    logic          cpu_rd_ret;

    assign cpu_idle = (state == C_IDLE);

    vram_arb_starve #(.MAX_CPU_WAIT(MAX_CPU_WAIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu.cpu_req),
        .cpu_idle   (cpu_idle),
        .vid_won    (issue_vid),
        .cpu_issued (issue_cpu),
        .force_cpu  (force_cpu)
    );

    always_comb begin
        issue_cpu = 1'b0;
        issue_vid = 1'b0;
        if (force_cpu)
            issue_cpu = 1'b1;
        else if (vid_req || lat_full)
            issue_vid = 1'b1;
        else if (cpu_idle && cpu.cpu_req)
            issue_cpu = 1'b1;
    end

    // The latched request is older than a fresh strobe, so it goes first.
    assign vid_issue_addr = lat_full ? lat_addr : vid_addr;

    always_comb begin
        state_nx = state;
        case (state)
            C_IDLE:   if (issue_cpu)    state_nx = C_ISSUED;
            C_ISSUED: if (cpu.cpu_ack)  state_nx = C_HOLD;
            C_HOLD:   if (!cpu.cpu_req) state_nx = C_IDLE;
            default:                    state_nx = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= C_IDLE;
        else     state <= state_nx;
    end

    // A strobe only overruns when the latch is occupied and is not draining this
    // cycle; when the latch is issued the new strobe simply takes its place.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_full    <= 1'b0;
            lat_addr    <= '0;
            vid_overrun <= 1'b0;
        end else if (vid_req && (lat_full || !issue_vid)) begin
            if (!lat_full || issue_vid) begin
                lat_full <= 1'b1;
                lat_addr <= vid_addr;
            end else begin
                vid_overrun <= 1'b1;
            end
        end else if (issue_vid) begin
            lat_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_din <= '0;
            tag_mem <= T_NONE;
            tag_ret <= T_NONE;
            we_ret  <= 1'b0;
        end else begin
            mem_ce  <= issue_cpu || issue_vid;
            mem_we  <= issue_cpu && cpu.cpu_we;
            tag_mem <= issue_cpu ? T_CPU : (issue_vid ? T_VID : T_NONE);
            tag_ret <= tag_mem;
            we_ret  <= mem_we;
            if (issue_cpu) begin
                mem_a   <= cpu.cpu_addr;
                mem_din <= cpu.cpu_din;
            end else if (issue_vid) begin
                mem_a   <= vid_issue_addr;
            end
        end
    end

    assign vid_valid    = (tag_ret == T_VID);
    assign cpu.cpu_ack  = (tag_ret == T_CPU);
    assign cpu_rd_ret   = cpu.cpu_ack && !we_ret;
    assign cpu.cpu_wait = cpu.cpu_req && !cpu.cpu_ack && (state != C_HOLD);

    // Return data is shown straight from the RAM on the valid/ack cycle and
    // held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (vid_valid)  vid_hold <= mem_dout;
            if (cpu_rd_ret) cpu_hold <= mem_dout;
        end
    end

    assign vid_data     = vid_valid  ? mem_dout : vid_hold;
    assign cpu.cpu_dout = cpu_rd_ret ? mem_dout : cpu_hold;
endmodule
